// File: rtl/pipeline_ctrl_pkg.sv
// Shared opcodes, ALUOp encodings and hazard-controller state type for the
// 5-stage MIPS pipeline control path.
package pipeline_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_t;

  // lw writes rt rather than reading it, so only these formats source rt.
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the
// instruction currently in ID.
module load_use_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [5:0]            i_opcode_id,
  input  logic [REG_ADDR_W-1:0] i_rs_id,
  input  logic [REG_ADDR_W-1:0] i_rt_id,
  input  logic                  i_memread_ex,
  input  logic [REG_ADDR_W-1:0] i_rt_ex,
  output logic                  o_load_use
);

  logic w_uses_rt, w_rs_hit, w_rt_hit, w_dst_live;

  assign w_uses_rt  = op_uses_rt(i_opcode_id);
  // $zero is never written, so a load targeting it creates no dependency.
  assign w_dst_live = i_memread_ex && (i_rt_ex != '0);
  assign w_rs_hit   = (i_rt_ex == i_rs_id);
  assign w_rt_hit   = w_uses_rt && (i_rt_ex == i_rt_id);
  assign o_load_use = w_dst_live && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: stall/flush/bubble/hold decisions plus memory-wait FSM
// with sticky timeout. PIPELINE_HAZARD_STALL_CNT_EN adds a stall_count output.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            opcode_id,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic                  memread_ex,
  input  logic [REG_ADDR_W-1:0] rt_ex,
  input  logic                  branch_taken_mem,
  input  logic                  mem_access_mem,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ctrl_bubble,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  pipe_hold,
  output logic                  mem_err
`ifdef PIPELINE_HAZARD_STALL_CNT_EN
  ,output logic [15:0]          stall_count
`endif
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

  hz_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt, w_cnt_nxt;
  logic             r_mem_err, w_err_nxt;
  logic             w_mem_stall, w_load_use;

  assign w_mem_stall = mem_access_mem && !dmem_ready;
  assign mem_err     = r_mem_err;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
    .i_opcode_id  (opcode_id),
    .i_rs_id      (rs_id),
    .i_rt_id      (rt_id),
    .i_memread_ex (memread_ex),
    .i_rt_ex      (rt_ex),
    .o_load_use   (w_load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_cnt_nxt;
      r_mem_err  <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_wait_cnt;
    w_err_nxt   = r_mem_err;
    case (r_state)
      RUN: if (w_mem_stall) begin
        w_state_nxt = MEM_WAIT;
        w_cnt_nxt   = CNT_W'(1);
      end
      // Ready or a withdrawn request both end the wait.
      MEM_WAIT: if (!w_mem_stall) begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end else if (r_wait_cnt >= TMO) begin
        w_state_nxt = ERROR;
        w_err_nxt   = 1'b1;
      end else begin
        w_cnt_nxt   = r_wait_cnt + CNT_W'(1);
      end
      ERROR:   w_state_nxt = ERROR;
      default: w_state_nxt = RUN;
    endcase
  end

  // A held EX/MEM keeps branch_taken_mem alive, so a branch seen during a
  // memory stall flushes on the ready cycle instead.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ctrl_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ctrl_bubble = 1'b1;
    end else if (r_state == ERROR || w_mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_hold   = 1'b1;
    end else if (branch_taken_mem) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (w_load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ctrl_bubble = 1'b1;
    end
  end

`ifdef PIPELINE_HAZARD_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  assign stall_count = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (!pc_write && r_state != ERROR && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for single-cycle
// decisions plus hand-written memory-wait, deferred-branch and timeout sequences.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode_id;
  logic [4:0] rs_id, rt_id, rt_ex;
  logic       memread_ex, branch_taken_mem, mem_access_mem, dmem_ready;
  logic       pc_write, ifid_write, ctrl_bubble, ifid_flush, idex_flush, exmem_flush;
  logic       pipe_hold, mem_err;
`ifdef PIPELINE_HAZARD_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;

  // {pc_write, ifid_write, ctrl_bubble, ifid_flush, idex_flush, exmem_flush, pipe_hold, mem_err}
  localparam logic [7:0] E_NORM = 8'b1100_0000;
  localparam logic [7:0] E_LU   = 8'b0010_0000;
  localparam logic [7:0] E_BR   = 8'b1101_1100;
  localparam logic [7:0] E_HOLD = 8'b0000_0010;
  localparam logic [7:0] E_ERR  = 8'b0000_0011;
  localparam logic [7:0] E_RST  = 8'b0010_0000;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
    .memread_ex(memread_ex), .rt_ex(rt_ex), .branch_taken_mem(branch_taken_mem),
    .mem_access_mem(mem_access_mem), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ctrl_bubble(ctrl_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .pipe_hold(pipe_hold), .mem_err(mem_err)
`ifdef PIPELINE_HAZARD_STALL_CNT_EN
    ,.stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mr;
    logic [4:0] rtx;
    logic       br;
    logic       acc;
    logic       rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {pc_write, ifid_write, ctrl_bubble, ifid_flush, idex_flush, exmem_flush,
           pipe_hold, mem_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] rtx, input logic br,
                       input logic acc, input logic rdy);
    opcode_id = op; rs_id = rs; rt_id = rt; memread_ex = mr; rt_ex = rtx;
    branch_taken_mem = br; mem_access_mem = acc; dmem_ready = rdy;
  endtask

  // Check at the negedge, then advance past the next rising edge.
  task automatic cyc(input string name, input logic [7:0] exp);
    @(negedge clk);
    chk(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, E_NORM}; // plain R-type
    vecs[1]  = '{6'b000000, 5'd8, 5'd9, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, E_LU};   // rs hit
    vecs[2]  = '{6'b000000, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, E_NORM}; // $zero dest
    vecs[3]  = '{6'b100011, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, E_NORM}; // lw rt no read
    vecs[4]  = '{6'b101011, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, E_LU};   // sw rt hit
    vecs[5]  = '{6'b000100, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, E_LU};   // beq rt hit
    vecs[6]  = '{6'b001000, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, E_NORM}; // addi rt no read
    vecs[7]  = '{6'b000000, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, E_LU};   // R rt hit
    vecs[8]  = '{6'b000000, 5'd8, 5'd8, 1'b0, 5'd8, 1'b0, 1'b0, 1'b1, E_NORM}; // not a load
    vecs[9]  = '{6'b000000, 5'd8, 5'd9, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, E_BR};   // branch beats LU
    vecs[10] = '{6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, E_BR};   // branch alone
    vecs[11] = '{6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, E_NORM}; // mem ready

    rst_n = 1'b0;
    idle();
    @(negedge clk);
    chk("reset_outputs", E_RST);
`ifdef PIPELINE_HAZARD_STALL_CNT_EN
    checks++;
    if (stall_count !== 16'd0) begin
      errors++;
      $display("FAIL stall_count_reset: got %0d expected 0", stall_count);
    end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].mr, vecs[i].rtx,
            vecs[i].br, vecs[i].acc, vecs[i].rdy);
      cyc($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Fresh reset so the stall counter covers exactly load-use + 3-cycle wait.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    drive(6'b000000, 5'd8, 5'd9, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
    cyc("lu_bubble", E_LU);
    drive(6'b000000, 5'd8, 5'd9, 1'b0, 5'd8, 1'b0, 1'b0, 1'b1);
    cyc("lu_after", E_NORM);
    idle(); mem_access_mem = 1'b1; dmem_ready = 1'b0;
    cyc("wait1", E_HOLD);
    cyc("wait2", E_HOLD);
    cyc("wait3", E_HOLD);
    dmem_ready = 1'b1;
    cyc("wait_ready", E_NORM);
`ifdef PIPELINE_HAZARD_STALL_CNT_EN
    @(negedge clk);
    checks++;
    if (stall_count !== 16'd4) begin
      errors++;
      $display("FAIL stall_count: got %0d expected 4", stall_count);
    end
    @(posedge clk);
    #1;
`endif

    // Branch resolved while memory stalls: flush only in the ready cycle.
    idle(); branch_taken_mem = 1'b1; mem_access_mem = 1'b1; dmem_ready = 1'b0;
    cyc("defer1", E_HOLD);
    cyc("defer2", E_HOLD);
    dmem_ready = 1'b1;
    cyc("defer_flush", E_BR);

    // Withdrawn request must clear the wait count.
    idle(); mem_access_mem = 1'b1; dmem_ready = 1'b0;
    cyc("wd1", E_HOLD);
    cyc("wd2", E_HOLD);
    mem_access_mem = 1'b0;
    cyc("wd_release", E_NORM);

    // Timeout at 4: error after the 5th consecutive stalled cycle.
    mem_access_mem = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 5; i++) cyc($sformatf("tmo_stall%0d", i), E_HOLD);
    idle(); branch_taken_mem = 1'b1;
    cyc("err_hold", E_ERR);
    dmem_ready = 1'b1; mem_access_mem = 1'b1;
    cyc("err_sticky", E_ERR);

    // Asynchronous reset in the middle of a cycle.
    #2 rst_n = 1'b0;
    #1 chk("err_async_reset", E_RST);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    cyc("post_reset_run", E_NORM);
    mem_access_mem = 1'b1; dmem_ready = 1'b0;
    cyc("post_reset_stall", E_HOLD);
    dmem_ready = 1'b1;
    cyc("post_reset_ready", E_NORM);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage MIPS pipeline around the main control decoder.
- Decides per cycle whether the PC and IF/ID advance, stall or flush.
- Inserts bubbles by forcing the decoder's control word to zero entering ID/EX.
- Freezes the whole pipeline while data memory is not ready, and latches a sticky error on memory timeout.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- MEM_TIMEOUT, 16, max consecutive not-ready cycles before error (valid 1..255).
- CNT_W, 8, width of the internal wait counter (must hold MEM_TIMEOUT).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode_id  in  6  opcode of instruction in ID.
- rs_id  in  REG_ADDR_W  rs of instruction in ID.
- rt_id  in  REG_ADDR_W  rt of instruction in ID.
- memread_ex  in  1  MemRead of instruction in EX.
- rt_ex  in  REG_ADDR_W  destination rt of instruction in EX.
- branch_taken_mem  in  1  Branch & zero resolved in MEM.
- mem_access_mem  in  1  MemRead|MemWrite of instruction in MEM.
- dmem_ready  in  1  data memory completes access this cycle.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID load enable.
- ctrl_bubble  out  1  zero control word into ID/EX.
- ifid_flush, idex_flush, exmem_flush  out  1 each  clear the respective pipeline register.
- pipe_hold  out  1  hold ID/EX, EX/MEM, MEM/WB.
- mem_err  out  1  sticky memory-timeout flag.

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Registers: state, wait_cnt[CNT_W], mem_err. All outputs are combinational from state and inputs.
- Reset (rst_n=0, asynchronous):
  - state=RUN, wait_cnt=0, mem_err=0.
  - While rst_n=0 outputs are forced: pc_write=0, ifid_write=0, ctrl_bubble=1, all flushes=0, pipe_hold=0.
  - Reset mid-wait or mid-error returns to RUN immediately.
- mem_stall = mem_access_mem & ~dmem_ready.
- uses_rt = opcode_id in {000000 R-type, 101011 sw, 000100 beq}. lw and all other opcodes do not read rt.
- load_use = memread_ex & (rt_ex!=0) & ((rt_ex==rs_id) | (uses_rt & rt_ex==rt_id)).
- Priority per cycle: ERROR > mem_stall > branch_taken_mem > load_use > normal.
  - ERROR: pc_write=0, ifid_write=0, pipe_hold=1, ctrl_bubble=0, flushes=0, mem_err=1. Held until reset.
  - mem_stall: pc_write=0, ifid_write=0, pipe_hold=1, no flush, no bubble. A pending branch flush is deferred; branch_taken_mem stays valid because EX/MEM is held.
  - branch: pc_write=1, ifid_write=1, ifid_flush=idex_flush=exmem_flush=1. A coincident load_use is discarded because the stalled instruction is being flushed.
  - load_use: pc_write=0, ifid_write=0, ctrl_bubble=1. Exactly one bubble per hazard, since the load leaves EX next cycle.
  - normal: pc_write=1, ifid_write=1, everything else 0.
- FSM transitions:
  - RUN & mem_stall -> MEM_WAIT, wait_cnt=1.
  - MEM_WAIT & dmem_ready -> RUN, wait_cnt=0. Hold drops in the ready cycle itself, so there is zero-cycle release latency.
  - MEM_WAIT & mem_stall: if wait_cnt==MEM_TIMEOUT -> ERROR, mem_err<=1; else wait_cnt+1.
  - MEM_WAIT & ~mem_access_mem (requester withdrew) -> RUN, wait_cnt=0.
- wait_cnt never wraps; it saturates at MEM_TIMEOUT.
- rt_ex==0 never triggers load_use ($zero is not written).

Optional Feature:
- Macro: PIPELINE_HAZARD_STALL_CNT_EN.
- When defined:
  - Adds output stall_count[15:0], reset to 0.
  - Increments each cycle pc_write=0 while rst_n=1 and state!=ERROR.
  - Saturates at 16'hFFFF.
- When undefined: port and counter are absent; all other behaviour is unchanged.

Decomposition:
- Package pipeline_ctrl_pkg:
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ.
  - Typedef hz_state_t {RUN, MEM_WAIT, ERROR}.
  - ALUOp encodings shared with the main decoder.
- Sub-module: load_use_detect, a combinational block from uses_rt/compare logic to the load_use bit. The FSM and priority mux stay in the top.

Test Plan:
- Load-use: lw $t0 in EX (memread_ex=1, rt_ex=8), add with rs_id=8 in ID -> exactly 1 cycle of pc_write=0, ifid_write=0, ctrl_bubble=1, then normal. Repeat with rt_ex=0 -> no stall. Repeat with lw in ID, rt_id=8 -> no stall.
- Branch: branch_taken_mem=1 with coincident load_use -> all three flushes=1, pc_write=1, ctrl_bubble=0.
- Memory wait: mem_access_mem=1, dmem_ready=0 for 3 cycles, then 1 -> pipe_hold=1 for 3 cycles, 0 in the ready cycle; state returns to RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> ERROR entered after the 5th stalled cycle, mem_err=1 sticky; then rst_n=0 mid-ERROR -> mem_err=0 asynchronously, state RUN.
- Deferred branch: branch_taken_mem=1 during mem_stall -> no flush while held, flushes asserted in the dmem_ready cycle.
- With PIPELINE_HAZARD_STALL_CNT_EN: the load-use scenario plus a 3-cycle memory wait -> stall_count=4.
